ctrl_hazard_pipe: RTL and testbench
===================================

Name: ctrl_hazard_pipe

Overview:
- Consumes the 18-bit decoded control bundle produced by the ID-stage controller, together with the ID register specifiers.
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and resolves jumps (in ID) and branches (in EX), generating PC/IF-ID stall, IF/ID flush and bubble insertion.
- Drives EX-stage forwarding selects and a saturating stall/flush event counter.

Parameters:
CTRL_W, 18, control bundle width; field map fixed below, CTRL_W must stay 18.
CNT_W, 16, width of each event counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
id_ctrl  in  18  ID bundle {RegDst[17:16],Jmp[15:14],DataC[13],Regwrite[12],AluSrc[11],AluSrc1[10],Branch[9],MemRead[8],MemWrite[7],MemtoReg[6],AluOperation[5:2],not_equal_Branch[1],flush[0]}.
id_rs  in  5  rs of instruction in ID.
id_rt  in  5  rt of instruction in ID.
id_rd  in  5  rd of instruction in ID.
ex_zero  in  1  ALU zero flag of instruction in EX.
ex_ctrl  out  18  ID/EX control register.
mem_ctrl  out  18  EX/MEM control register.
wb_ctrl  out  18  MEM/WB control register.
ex_rs, ex_rt  out  5 each  registered specifiers in EX.
mem_dest, wb_dest  out  5 each  destination register in MEM / WB.
pc_write  out  1  0 = hold PC.
ifid_write  out  1  0 = hold IF/ID.
ifid_flush  out  1  1 = IF/ID loads NOP at next edge.
branch_taken  out  1  EX branch resolved taken.
fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (rst=0, async): all control/specifier/dest registers and counters = 0. Combinational outputs follow from zeroed state: pc_write=1, ifid_write=1, ifid_flush=0, fwd=00. Reset mid-stream discards all in-flight state.
- Dest in ID: RegDst 00→id_rt, 01→id_rd, 10→5'd31, 11→0. Registered with the bundle as ex_dest, then mem_dest, then wb_dest.
- uses_rt = !AluSrc | MemWrite | Branch | not_equal_Branch, evaluated on id_ctrl.
- load_use = ex_ctrl.MemRead & ex_dest≠0 & (ex_dest==id_rs | (uses_rt & ex_dest==id_rt)).
- branch_taken (comb) = (ex_ctrl.Branch & ex_zero) | (ex_ctrl.not_equal_Branch & !ex_zero).
- jump_id = id_ctrl.Jmp≠00.
- Priority, highest first:
  - branch_taken: ifid_flush=1, ID/EX loads zero bubble, pc_write=1, no stall even if load_use.
  - load_use: pc_write=0, ifid_write=0, ID/EX loads zero bubble.
  - jump_id: ifid_flush=1; ID bundle advances normally (jal/jalr link write proceeds).
- EX/MEM ← ID/EX and MEM/WB ← EX/MEM every cycle, unconditionally. Bubbles travel downstream as all-zero bundles.
- Forwarding, for ex_rs→fwd_a and ex_rt→fwd_b:
  - 01 if mem_ctrl.Regwrite & mem_dest≠0 & mem_dest==src;
  - else 10 if wb_ctrl.Regwrite & wb_dest≠0 & wb_dest==src;
  - else 00. MEM beats WB on a double match; register $0 never forwards.
- Counters: stall_cnt +1 per load_use stall cycle; flush_cnt +1 per ifid_flush cycle. Both saturate at all-ones with no wrap.
- Latency: a bundle appears on ex_ctrl 1 cycle after ID, mem_ctrl 2 cycles, wb_ctrl 3 cycles. Stall/flush/forward outputs are combinational in the same cycle.

Test Plan:
- Reset: rst low mid-stream → all ctrl outputs 0, counters 0, pc_write=1; rst high → add (id_ctrl Regwrite|RegDst=01) reaches wb_ctrl in 3 edges.
- Load-use: lw $8 then add $9,$8,$10 → one cycle of pc_write=0, ifid_write=0; ex_ctrl=0 next edge; stall_cnt=1; add then gets fwd_a=10.
- Forward priority: add $8 followed by add $8 then add $3,$8,$8 → fwd_a=fwd_b=01; with only an older writer → 10; writer to $0 → 00.
- Branch: beq in EX with ex_zero=1 → branch_taken=1, ifid_flush=1, ex_ctrl=0 next edge; with ex_zero=0 → no flush. bne: the inverse.
- Branch with concurrent load-use in ID → branch wins: pc_write=1, stall_cnt unchanged, flush_cnt+1.
- jal in ID → ifid_flush=1 same cycle; ex_ctrl carries RegDst=10, ex_dest=31; forced 2^16 stall cycles → stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/ctrl_hazard_pipe.sv
// ctrl_hazard_pipe: carries the decoded control bundle from ID through the
// EX, MEM and WB control registers. It also detects load-use and
// control-flow hazards, drives the EX-stage forwarding selects, and keeps
// saturating counters of stall and flush events.
module ctrl_hazard_pipe #(
  parameter int CTRL_W = 18,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              ex_zero,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        mem_dest,
  output logic [4:0]        wb_dest,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              branch_taken,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Bundle field positions.
  localparam int REGDST_HI = 17;
  localparam int REGDST_LO = 16;
  localparam int JMP_HI    = 15;
  localparam int JMP_LO    = 14;
  localparam int REGWRITE  = 12;
  localparam int ALUSRC    = 11;
  localparam int BRANCH    = 9;
  localparam int MEMREAD   = 8;
  localparam int MEMWRITE  = 7;
  localparam int BNE       = 1;

  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
  logic [CTRL_W-1:0] wb_ctrl_q,  wb_ctrl_d;
  logic [4:0]        ex_rs_q,    ex_rs_d;
  logic [4:0]        ex_rt_q,    ex_rt_d;
  logic [4:0]        ex_dest_q,  ex_dest_d;
  logic [4:0]        mem_dest_q, mem_dest_d;
  logic [4:0]        wb_dest_q,  wb_dest_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [4:0] id_dest;
  logic       uses_rt;
  logic       load_use;
  logic       jump_id;
  logic       taken;
  logic       stall;
  logic       flush;
  logic       bubble;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}})) r = v + 1'b1;
    return r;
  endfunction

  // Forwarding select for one EX source. The younger MEM-stage writer wins
  // over WB, and $0 is never forwarded because it is hardwired to zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_wr, input logic [4:0] mem_d,
                                         input logic wb_wr,  input logic [4:0] wb_d);
    logic [1:0] s;
    s = 2'b00;
    if (mem_wr && (mem_d != 5'd0) && (mem_d == src))    s = 2'b01;
    else if (wb_wr && (wb_d != 5'd0) && (wb_d == src))  s = 2'b10;
    return s;
  endfunction

  // Hazard detection, stall/flush priority and next state of the pipeline registers.
  always_comb begin
    id_dest = 5'd0;
    case (id_ctrl[REGDST_HI:REGDST_LO])
      2'b00:   id_dest = id_rt;
      2'b01:   id_dest = id_rd;
      2'b10:   id_dest = 5'd31;
      default: id_dest = 5'd0;
    endcase

    uses_rt  = !id_ctrl[ALUSRC] | id_ctrl[MEMWRITE] | id_ctrl[BRANCH] | id_ctrl[BNE];
    load_use = ex_ctrl_q[MEMREAD] && (ex_dest_q != 5'd0) &&
               ((ex_dest_q == id_rs) || (uses_rt && (ex_dest_q == id_rt)));
    taken    = (ex_ctrl_q[BRANCH] & ex_zero) | (ex_ctrl_q[BNE] & ~ex_zero);
    jump_id  = (id_ctrl[JMP_HI:JMP_LO] != 2'b00);

    // A taken branch kills the instruction in ID, so any load-use stall it
    // would have caused is moot. A stalled jump re-presents itself next cycle,
    // so it must not flush while held.
    stall  = load_use & ~taken;
    flush  = taken | (jump_id & ~load_use);
    bubble = taken | load_use;

    ex_ctrl_d   = bubble ? '0   : id_ctrl;
    ex_rs_d     = bubble ? 5'd0 : id_rs;
    ex_rt_d     = bubble ? 5'd0 : id_rt;
    ex_dest_d   = bubble ? 5'd0 : id_dest;
    mem_ctrl_d  = ex_ctrl_q;
    mem_dest_d  = ex_dest_q;
    wb_ctrl_d   = mem_ctrl_q;
    wb_dest_d   = mem_dest_q;
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    flush_cnt_d = sat_inc(flush_cnt_q, flush);
  end

  // ID/EX, EX/MEM and MEM/WB control and specifier registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_ctrl_q  <= '0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
      ex_rs_q    <= 5'd0;
      ex_rt_q    <= 5'd0;
      ex_dest_q  <= 5'd0;
      mem_dest_q <= 5'd0;
      wb_dest_q  <= 5'd0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_dest_q  <= ex_dest_d;
      mem_dest_q <= mem_dest_d;
      wb_dest_q  <= wb_dest_d;
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_ctrl      = ex_ctrl_q;
  assign mem_ctrl     = mem_ctrl_q;
  assign wb_ctrl      = wb_ctrl_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign mem_dest     = mem_dest_q;
  assign wb_dest      = wb_dest_q;
  assign pc_write     = ~stall;
  assign ifid_write   = ~stall;
  assign ifid_flush   = flush;
  assign branch_taken = taken;
  assign fwd_a        = fwd_sel(ex_rs_q, mem_ctrl_q[REGWRITE], mem_dest_q,
                                wb_ctrl_q[REGWRITE], wb_dest_q);
  assign fwd_b        = fwd_sel(ex_rt_q, mem_ctrl_q[REGWRITE], mem_dest_q,
                                wb_ctrl_q[REGWRITE], wb_dest_q);
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Testbench for ctrl_hazard_pipe. The driver issues one ID-stage
// instruction per cycle and queues the expected outputs. The monitor
// compares them at the falling edge. The reference model keeps a short
// history of what entered EX on each cycle.
module tb_ctrl_hazard_pipe;

  localparam int CNT_W = 10;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [17:0] C_NOP  = 18'd0;
  localparam logic [17:0] C_ADD  = 18'b01_00_0_1_0_0_0_0_0_0_0010_0_0;
  localparam logic [17:0] C_ADDI = 18'b00_00_0_1_1_0_0_0_0_0_0010_0_0;
  localparam logic [17:0] C_LW   = 18'b00_00_0_1_1_0_0_1_0_1_0010_0_0;
  localparam logic [17:0] C_SW   = 18'b00_00_0_0_1_0_0_0_1_0_0010_0_0;
  localparam logic [17:0] C_BEQ  = 18'b00_00_0_0_0_0_1_0_0_0_0110_0_0;
  localparam logic [17:0] C_BNE  = 18'b00_00_0_0_0_0_0_0_0_0_0110_1_0;
  localparam logic [17:0] C_JAL  = 18'b10_01_0_1_0_0_0_0_0_0_0000_0_0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [17:0] id_ctrl = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic ex_zero = 1'b0;
  logic [17:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_rs, ex_rt, mem_dest, wb_dest;
  logic pc_write, ifid_write, ifid_flush, branch_taken;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  ctrl_hazard_pipe #(.CTRL_W(18), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_dest(mem_dest),
    .wb_dest(wb_dest), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .branch_taken(branch_taken), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] c;
    logic [4:0]  rs, rt, d;
  } instr_t;

  typedef struct {
    logic [17:0] exc, memc, wbc;
    logic [4:0]  exrs, exrt, memd, wbd;
    logic        pcw, ifw, fl, bt;
    logic [1:0]  fa, fb;
    int          sc, fc;
  } exp_t;

  exp_t   expq[$];
  instr_t hist[$];   // [0]=in WB, [1]=in MEM, [2]=in EX
  int     n_stall, n_flush;
  int     errors = 0;
  int     checks = 0;

  function automatic logic [4:0] dest_of(input logic [17:0] c, input logic [4:0] rt,
                                         input logic [4:0] rd);
    case (c[17:16])
      2'b00:   return rt;
      2'b01:   return rd;
      2'b10:   return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  // Which older instruction (if any) supplies src: 1 = the one in MEM, 2 = in WB.
  function automatic logic [1:0] source_of(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (hist[1].c[12] && hist[1].d == src) return 2'b01;
    if (hist[0].c[12] && hist[0].d == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic model_reset();
    instr_t z;
    z = '{c: '0, rs: '0, rt: '0, d: '0};
    hist = {};
    repeat (3) hist.push_back(z);
    n_stall = 0;
    n_flush = 0;
  endtask

  task automatic step(input logic [17:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic z, input logic r);
    instr_t ex, nw;
    exp_t   e;
    logic   bt, lu, jmp, urt, stall, flush;
    @(posedge clk);
    #1;
    rst = r; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
    if (!r) model_reset();
    ex  = hist[2];
    bt  = (ex.c[9] && z) || (ex.c[1] && !z);
    urt = !c[11] || c[7] || c[9] || c[1];
    lu  = ex.c[8] && ex.d != 0 && (ex.d == rs || (urt && ex.d == rt));
    jmp = c[15:14] != 2'b00;
    stall = lu && !bt;
    flush = bt || (jmp && !lu);
    e.exc = ex.c; e.memc = hist[1].c; e.wbc = hist[0].c;
    e.exrs = ex.rs; e.exrt = ex.rt; e.memd = hist[1].d; e.wbd = hist[0].d;
    e.pcw = !stall; e.ifw = !stall; e.fl = flush; e.bt = bt;
    e.fa = source_of(ex.rs); e.fb = source_of(ex.rt);
    e.sc = sat(n_stall); e.fc = sat(n_flush);
    expq.push_back(e);
    if (r) begin
      if (bt || lu) nw = '{c: '0, rs: '0, rt: '0, d: '0};
      else          nw = '{c: c, rs: rs, rt: rt, d: dest_of(c, rt, rd)};
      hist.push_back(nw);
      void'(hist.pop_front());
      if (stall) n_stall++;
      if (flush) n_flush++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exv);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("ex_ctrl", 32'(ex_ctrl), 32'(e.exc));
      chk("mem_ctrl", 32'(mem_ctrl), 32'(e.memc));
      chk("wb_ctrl", 32'(wb_ctrl), 32'(e.wbc));
      chk("ex_rs", 32'(ex_rs), 32'(e.exrs));
      chk("ex_rt", 32'(ex_rt), 32'(e.exrt));
      chk("mem_dest", 32'(mem_dest), 32'(e.memd));
      chk("wb_dest", 32'(wb_dest), 32'(e.wbd));
      chk("pc_write", 32'(pc_write), 32'(e.pcw));
      chk("ifid_write", 32'(ifid_write), 32'(e.ifw));
      chk("ifid_flush", 32'(ifid_flush), 32'(e.fl));
      chk("branch_taken", 32'(branch_taken), 32'(e.bt));
      chk("fwd_a", 32'(fwd_a), 32'(e.fa));
      chk("fwd_b", 32'(fwd_b), 32'(e.fb));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
    end
  end

  task automatic nops(input int n);
    repeat (n) step(C_NOP, 0, 0, 0, 0, 1'b1);
  endtask

  initial begin
    model_reset();
    // Reset, then an add walks to WB.
    step(C_NOP, 0, 0, 0, 0, 1'b0);
    step(C_NOP, 0, 0, 0, 0, 1'b0);
    step(C_ADD, 5'd1, 5'd2, 5'd3, 0, 1'b1);
    nops(4);
    // Load-use: lw $8 ; add $9,$8,$10 (stalled once, then re-presented).
    step(C_LW,  5'd1, 5'd8, 5'd0, 0, 1'b1);
    step(C_ADD, 5'd8, 5'd10, 5'd9, 0, 1'b1);
    step(C_ADD, 5'd8, 5'd10, 5'd9, 0, 1'b1);
    nops(3);
    // Forward priority: MEM beats WB; WB only; writer to $0.
    step(C_ADD, 5'd1, 5'd2, 5'd8, 0, 1'b1);
    step(C_ADD, 5'd1, 5'd2, 5'd8, 0, 1'b1);
    step(C_ADD, 5'd8, 5'd8, 5'd3, 0, 1'b1);
    nops(1);
    step(C_ADD, 5'd1, 5'd2, 5'd8, 0, 1'b1);
    nops(1);
    step(C_ADD, 5'd8, 5'd8, 5'd4, 0, 1'b1);
    nops(1);
    step(C_ADD, 5'd1, 5'd2, 5'd0, 0, 1'b1);
    step(C_ADD, 5'd0, 5'd0, 5'd5, 0, 1'b1);
    nops(3);
    // Branches: beq taken/not taken, bne taken/not taken.
    step(C_BEQ, 5'd1, 5'd2, 0, 0, 1'b1);
    step(C_ADD, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
    step(C_BEQ, 5'd1, 5'd2, 0, 0, 1'b1);
    step(C_ADD, 5'd1, 5'd2, 5'd6, 1'b0, 1'b1);
    step(C_BNE, 5'd1, 5'd2, 0, 0, 1'b1);
    step(C_ADD, 5'd1, 5'd2, 5'd6, 1'b0, 1'b1);
    step(C_BNE, 5'd1, 5'd2, 0, 0, 1'b1);
    step(C_ADD, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
    nops(2);
    // Branch resolving taken while a load-use hazard is also present.
    step(C_LW | 18'h00200, 5'd1, 5'd8, 0, 0, 1'b1);
    step(C_ADD, 5'd8, 5'd2, 5'd9, 1'b1, 1'b1);
    nops(3);
    // jal links to $31.
    step(C_JAL, 0, 0, 0, 0, 1'b1);
    nops(3);
    // Reset mid-stream with instructions in flight.
    step(C_ADD, 5'd1, 5'd2, 5'd7, 0, 1'b1);
    step(C_LW, 5'd1, 5'd7, 5'd0, 0, 1'b1);
    step(C_NOP, 0, 0, 0, 0, 1'b0);
    step(C_NOP, 0, 0, 0, 0, 1'b0);
    step(C_ADD, 5'd1, 5'd2, 5'd3, 0, 1'b1);
    nops(3);
    // Randomised traffic over a small register set to provoke hazards.
    for (int i = 0; i < 800; i++) begin
      logic [17:0] c;
      case ($urandom_range(0, 7))
        0: c = C_ADD;  1: c = C_ADDI; 2: c = C_LW;  3: c = C_SW;
        4: c = C_BEQ;  5: c = C_BNE;  6: c = C_JAL;
        default: c = 18'($urandom);
      endcase
      step(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom), 1'b1);
    end
    // Saturation of both counters.
    repeat (CMAX + 60) step(C_JAL, 0, 0, 0, 0, 1'b1);
    repeat (CMAX + 60) begin
      step(C_LW,  5'd1, 5'd8, 5'd0, 0, 1'b1);
      step(C_ADD, 5'd8, 5'd10, 5'd9, 0, 1'b1);
    end
    nops(2);
    @(negedge clk);
    #1;
    chk("drain", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
